tl_ram_slave: RTL
=================

Name: tl_ram_slave

Overview:
- Single-port TileLink-UL responder (slave end) fronting an on-chip word-addressed RAM.
- Answers Get/PutFullData/PutPartialData from one master: the CPU fetch or access port, or an upstream arbiter output.
- Single outstanding transaction, configurable response latency, denied responses for illegal requests.
- Other end of the CPU's master-side bus and request handshake.

Parameters:
- ADDR_BASE, 64'h0000_0000_8000_0000, byte address of RAM word 0.
- DEPTH_WORDS, 4096, number of 64-bit words (power of two).
- LATENCY, 1, cycles from A-accept to first d_valid (legal 1..4).
- SOURCE_W, 4, width of a_source/d_source.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- a_valid  in  1  A-channel request valid
- a_ready  out  1  A-channel accept
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get
- a_size  in  3  log2 bytes (0..3 legal)
- a_source  in  SOURCE_W  requester tag
- a_address  in  64  byte address
- a_mask  in  8  byte-lane enables
- a_data  in  64  write data
- d_valid  out  1  D-channel response valid
- d_ready  in  1  D-channel accept
- d_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_size  out  3  echo of a_size
- d_source  out  SOURCE_W  echo of a_source
- d_denied  out  1  request rejected
- d_data  out  64  read data (full word, lanes per address)

Behaviour:
- Reset: state IDLE; a_ready=0 while rst=1. d_valid=0, d_opcode=0, d_size=0, d_source=0, d_denied=0, d_data=0. RAM contents not reset.
- A transfer fires when a_valid & a_ready. D transfer fires when d_valid & d_ready.
- FSM IDLE -> WAIT -> RESP -> IDLE.
- IDLE: a_ready=1.
  - On A fire: latch opcode/size/source/address/mask/data and compute legality.
  - Go to RESP if LATENCY=1, else WAIT with cnt=LATENCY-1.
- WAIT: a_ready=0; cnt decrements each cycle; at cnt==1 go to RESP.
- RESP: a_ready=0, d_valid=1, all d_* fields stable until D fire. On D fire go to IDLE, d_valid=0 next cycle.
- A-accept at cycle N -> d_valid first high at N+LATENCY.
- Min throughput: one transaction per LATENCY+1 cycles. No A accept in the same cycle as D fire.
- Legality: illegal = any of
  - opcode not in {0,1,4};
  - a_size>3;
  - address not aligned to 2^a_size;
  - (address-ADDR_BASE)>>3 >= DEPTH_WORDS, or address<ADDR_BASE.
- Word index = (address-ADDR_BASE)[log2(DEPTH_WORDS)+2:3].
- Put (legal): RAM write at the A-fire clock edge, byte lane i written iff a_mask[i]. mask=0 is a legal no-op write.
  - Response: d_opcode=0, d_denied=0, d_data=0.
- Get (legal): read word sampled on entering RESP (reflects all earlier writes).
  - Response: d_opcode=1, d_data=word, d_denied=0.
- Illegal: no RAM write. d_denied=1, d_data=0.
  - d_opcode=1 if a_opcode==4, else 0.
- d_size and d_source always echo the latched request.
- Back-pressure: d_ready low holds RESP indefinitely; d_data must not change even if RAM would.
- rst asserted in any state: next cycle IDLE, d_valid=0, in-flight response discarded. A Put already accepted stays written.

Test Plan:
- PutFull addr=0x8000_0010 size=3 mask=FF data=0x1122334455667788, then Get same addr, LATENCY=1 -> AccessAck d_denied=0 at N+1; then AccessAckData d_data=0x1122334455667788, d_source echoed.
- PutPartial addr=0x8000_0010 mask=0x0F data=0xAAAAAAAA_BBBBBBBB, then Get -> d_data=0x11223344_BBBBBBBB.
- Get addr=0x8000_8000 (DEPTH 4096 -> out of range), and Put addr=0x8000_0004 size=3 -> both d_denied=1, d_data=0; RAM word 0 unchanged on later Get.
- LATENCY=3, d_ready held low 5 cycles after d_valid -> d_valid at N+3, a_ready=0 throughout, d_* stable; after D fire a_ready=1 next cycle.
- rst pulsed while in WAIT after Get -> d_valid never asserts, a_ready=0 during rst and 1 the cycle after; next Get completes normally.
- Opcode 2 (Arithmetic) size=2 -> d_opcode=0, d_denied=1, no RAM change.

Source files
------------

// File: rtl/tl_ram_slave.sv
// tl_ram_slave: TileLink-UL responder (slave end) in front of an on-chip
// 64-bit word RAM. Serves Get / PutFullData / PutPartialData from a single
// master, one transaction outstanding. Illegal requests are answered with
// d_denied=1 and never touch the RAM.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   a_valid/a_ready     A-channel handshake (a_ready high only in IDLE)
//   a_opcode/a_size     request opcode (0 PutFull, 1 PutPartial, 4 Get), log2 bytes
//   a_source            requester tag, echoed on d_source
//   a_address           byte address (RAM word 0 sits at ADDR_BASE)
//   a_mask/a_data       byte-lane enables and write data
//   d_valid/d_ready     D-channel handshake
//   d_opcode            0 AccessAck, 1 AccessAckData
//   d_size/d_source     echo of the accepted request
//   d_denied            request was rejected
//   d_data              read data (full 64-bit word), zero for writes/denials
module tl_ram_slave #(
  parameter logic [63:0] ADDR_BASE   = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned SOURCE_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [63:0]         a_address,
  input  logic [7:0]          a_mask,
  input  logic [63:0]         a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [2:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic [63:0]         d_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  logic [2:0]          cnt;
  logic [2:0]          req_opcode;
  logic [2:0]          req_size;
  logic [SOURCE_W-1:0] req_source;
  logic [AW-1:0]       req_idx;
  logic                req_illegal;

  logic [63:0] mem [DEPTH_WORDS];

  // Request decode
  logic          a_fire;
  logic [63:0]   a_offset;
  logic [AW-1:0] a_idx;
  logic          a_misaligned;
  logic          a_bad_op;
  logic          a_out_of_range;
  logic          a_illegal;
  logic          a_is_put;

  assign a_ready = (state == IDLE) & ~rst;
  assign a_fire  = a_valid & a_ready;

  assign a_offset = a_address - ADDR_BASE;
  assign a_idx    = a_offset[AW+2:3];

  // ADDR_BASE is word aligned, so the low offset bits equal the low address bits.
  always_comb begin
    a_misaligned = 1'b0;
    case (a_size)
      3'd1:    a_misaligned = a_offset[0];
      3'd2:    a_misaligned = |a_offset[1:0];
      3'd3:    a_misaligned = |a_offset[2:0];
      default: a_misaligned = 1'b0;
    endcase
  end

  assign a_bad_op       = !((a_opcode == 3'd0) || (a_opcode == 3'd1) || (a_opcode == 3'd4));
  assign a_out_of_range = (a_address < ADDR_BASE) | (|a_offset[63:AW+3]);
  assign a_illegal      = a_bad_op | (a_size > 3'd3) | a_misaligned | a_out_of_range;
  assign a_is_put       = (a_opcode == 3'd0) || (a_opcode == 3'd1);

  // Response source: the live request when entering RESP straight from IDLE
  // (LATENCY=1), otherwise the latched request.
  logic [2:0]          sel_opcode;
  logic [2:0]          sel_size;
  logic [SOURCE_W-1:0] sel_source;
  logic [AW-1:0]       sel_idx;
  logic                sel_illegal;
  logic [2:0]          rsp_opcode;
  logic [63:0]         rsp_data;

  always_comb begin
    if (state == IDLE) begin
      sel_opcode  = a_opcode;
      sel_size    = a_size;
      sel_source  = a_source;
      sel_idx     = a_idx;
      sel_illegal = a_illegal;
    end else begin
      sel_opcode  = req_opcode;
      sel_size    = req_size;
      sel_source  = req_source;
      sel_idx     = req_idx;
      sel_illegal = req_illegal;
    end
  end

  always_comb begin
    rsp_opcode = (sel_opcode == 3'd4) ? 3'd1 : 3'd0;
    rsp_data   = '0;
    if ((sel_opcode == 3'd4) && !sel_illegal)
      rsp_data = mem[sel_idx];
  end

  // RAM write lands on the A-fire edge; earlier writes are therefore always
  // visible to the read sampled when entering RESP.
  always_ff @(posedge clk) begin
    if (a_fire && !a_illegal && a_is_put) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (a_mask[i])
          mem[a_idx][8*i +: 8] <= a_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_opcode  <= '0;
      req_size    <= '0;
      req_source  <= '0;
      req_idx     <= '0;
      req_illegal <= 1'b0;
      d_valid     <= 1'b0;
      d_opcode    <= '0;
      d_size      <= '0;
      d_source    <= '0;
      d_denied    <= 1'b0;
      d_data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_fire) begin
            req_opcode  <= a_opcode;
            req_size    <= a_size;
            req_source  <= a_source;
            req_idx     <= a_idx;
            req_illegal <= a_illegal;
            if (LATENCY == 1) begin
              state    <= RESP;
              d_valid  <= 1'b1;
              d_opcode <= rsp_opcode;
              d_size   <= sel_size;
              d_source <= sel_source;
              d_denied <= sel_illegal;
              d_data   <= rsp_data;
            end else begin
              state <= WAIT;
              cnt   <= 3'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state    <= RESP;
            d_valid  <= 1'b1;
            d_opcode <= rsp_opcode;
            d_size   <= sel_size;
            d_source <= sel_source;
            d_denied <= sel_illegal;
            d_data   <= rsp_data;
          end
        end
        RESP: begin
          if (d_ready) begin
            state   <= IDLE;
            d_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
